lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu.sv | 111 +++++++++++
 tb/tb_lsu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, access-size codes and bus width.
package lsu_pkg;

  localparam int MEM_BUS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; funct3[1:0] sets size, funct3[2] selects zero-extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [1:0]         off,
  input  logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic [3:0]         be,
  output logic [31:0]        wrep,
  output logic [MEM_BUS-1:0] rext,
  output logic               misalign
);

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        sx;

  assign bsel = rdata[{off, 3'b000} +: 8];
  assign hsel = off[1] ? rdata[31:16] : rdata[15:0];
  assign sx   = ~funct3[2];

  always_comb begin
    be       = 4'b1111;
    wrep     = wdata;
    rext     = rdata;
    misalign = |off;
    unique case (funct3[1:0])
      SZ_B: begin
        be       = 4'b0001 << off;
        wrep     = {4{wdata[7:0]}};
        rext     = {{24{sx & bsel[7]}}, bsel};
        misalign = 1'b0;
      end
      SZ_H: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        rext     = {{16{sx & hsel[15]}}, hsel};
        misalign = off[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/BUS request-acknowledge FSM on the data bus.
// LSU_MISALIGN_EXC_EN: misaligned accesses skip the bus and pulse misalign_o.
module lsu
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [MEM_BUS-1:0] rdata_o,
  output logic               misalign_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_addr_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [31:0]        dmem_rdata_i
);

  state_t             state, state_d;
  logic [2:0]         f3_q, f3_s;
  logic [1:0]         off_q, off_s;
  logic [3:0]         be_s;
  logic [31:0]        wrep_s;
  logic [MEM_BUS-1:0] rext_s;
  logic               mis_s, mis_hit;
  logic               accept, ack;

  // Align unit sees live inputs in IDLE, the latched access in BUS
  assign f3_s   = (state == IDLE) ? funct3_i : f3_q;
  assign off_s  = (state == IDLE) ? addr_i[1:0] : off_q;
  assign accept = (state == IDLE) & req_i;
  assign ack    = (state == BUS) & dmem_ack_i;
  assign busy_o = (state == BUS) | accept;

  lsu_align u_align (
    .funct3   (f3_s),
    .off      (off_s),
    .wdata    (wdata_i),
    .rdata    (dmem_rdata_i),
    .be       (be_s),
    .wrep     (wrep_s),
    .rext     (rext_s),
    .misalign (mis_s)
  );

`ifdef LSU_MISALIGN_EXC_EN
  assign mis_hit = mis_s;
`else
  logic unused_mis;
  assign unused_mis = mis_s;
  assign mis_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (req_i && !mis_hit) state_d = BUS;
      BUS:  if (dmem_ack_i) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q         <= '0;
      off_q        <= '0;
      done_o       <= 1'b0;
      misalign_o   <= 1'b0;
      rdata_o      <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      if (accept) begin
        if (mis_hit) begin
          done_o     <= 1'b1;
          misalign_o <= 1'b1;
        end else begin
          f3_q         <= funct3_i;
          off_q        <= addr_i[1:0];
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= we_i;
          dmem_be_o    <= be_s;
          dmem_addr_o  <= {addr_i[31:2], 2'b00};
          dmem_wdata_o <= wrep_s;
        end
      end else if (ack) begin
        dmem_req_o <= 1'b0;
        dmem_we_o  <= 1'b0;
        done_o     <= 1'b1;
        if (!dmem_we_o) rdata_o <= rext_s;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a size/lane model and a per-cycle compare.
module tb_lsu;

`ifdef LSU_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk, rst, req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misalign_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  logic        exp_req, exp_we, exp_done, exp_busy, exp_mis;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wd, exp_rdata;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  // Access size in bytes
  function automatic int nb(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Lowest byte lane touched: offset rounded down to the access size
  function automatic int lo(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) / nb(f3)) * nb(f3);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int m;
    m = ((1 << nb(f3)) - 1) << lo(f3, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nb(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [63:0] v, mask;
    int n;
    n    = nb(f3);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = ({32'b0, rd} >> (8 * lo(f3, a))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    return nb(f3) > 1 && (int'(a[1:0]) % nb(f3)) != 0;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("busy", busy_o, exp_busy);
      chk("done", done_o, exp_done);
      chk("misalign", misalign_o, exp_mis);
      chk("rdata", rdata_o, exp_rdata);
      chk("dmem_req", dmem_req_o, exp_req);
      if (exp_req) begin
        chk("dmem_we", dmem_we_o, exp_we);
        chk("dmem_be", dmem_be_o, exp_be);
        chk("dmem_addr", dmem_addr_o, exp_addr);
        if (exp_we) chk("dmem_wdata", dmem_wdata_o, exp_wd);
      end
    end
  end

  // Issue one access at posedge+1 of cycle 0; returns at posedge+1 of done
  task automatic op(input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] rd, input int k, input bit stray);
    req_i    = 1'b1;
    we_i     = w;
    funct3_i = f3;
    addr_i   = a;
    wdata_i  = wd;
    exp_busy = 1'b1;
    exp_req  = 1'b0;
    @(posedge clk); #1;
    req_i    = 1'b0;
    addr_i   = $urandom;
    wdata_i  = $urandom;
    funct3_i = 3'($urandom_range(0, 7));
    exp_done = 1'b0;
    exp_mis  = 1'b0;
    if (MIS_EN && m_mis(f3, a)) begin
      exp_done = 1'b1;
      exp_mis  = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    exp_req  = 1'b1;
    exp_we   = w;
    exp_be   = m_be(f3, a);
    exp_addr = a & ~32'd3;
    exp_wd   = m_wd(f3, wd);
    exp_busy = 1'b1;
    for (int i = 1; i <= k; i++) begin
      req_i        = stray && (i == 2);
      we_i         = stray ? ~w : w;
      dmem_ack_i   = (i == k);
      dmem_rdata_i = (i == k) ? rd : $urandom;
      @(posedge clk); #1;
    end
    dmem_ack_i = 1'b0;
    req_i      = 1'b0;
    exp_req    = 1'b0;
    exp_done   = 1'b1;
    exp_busy   = 1'b0;
    if (!w) exp_rdata = m_load(f3, a, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exp_done = 1'b0;
      exp_mis  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = '0;
    addr_i = '0; wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    {exp_req, exp_we, exp_done, exp_busy, exp_mis} = '0;
    exp_be = '0; exp_addr = '0; exp_wd = '0; exp_rdata = '0;

    chk("pin_lb", m_load(3'b000, 32'h103, 32'h80FF0000), 32'hFFFFFF80);
    chk("pin_lbu", m_load(3'b100, 32'h103, 32'h80FF0000), 32'h00000080);
    chk("pin_lh", m_load(3'b001, 32'h102, 32'h80FF0000), 32'hFFFF80FF);
    chk("pin_sh_be", m_be(3'b001, 32'h202), 32'hC);
    chk("pin_sh_wd", m_wd(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("pin_sb_be", m_be(3'b000, 32'h101), 32'h2);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    run = 1'b1;
    idle(1);

    op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    chk("lw_done", done_o, 1);
    chk("lw_rdata", rdata_o, 32'hDEADBEEF);
    idle(1);
    op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    chk("lb_rdata", rdata_o, 32'hFFFFFF80);
    idle(1);
    op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    chk("lbu_rdata", rdata_o, 32'h00000080);
    idle(1);
    op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, 1'b0);
    chk("sh_keep", rdata_o, 32'h00000080);
    idle(1);

    op(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 5, 1'b1);
    idle(2);

    op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1, 1'b0);
    op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 2, 1'b0);
    chk("lhu_rdata", rdata_o, 32'h000080FF);
    op(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 1'b0);
    op(1'b1, 3'b010, 32'h104, 32'h11223344, 32'h0, 3, 1'b0);
    idle(1);

    op(1'b0, 3'b011, 32'h108, 32'h0, 32'h55AA55AA, 1, 1'b0);
    idle(1);

    op(1'b0, 3'b010, 32'h101, 32'h0, 32'h76543210, 1, 1'b0);
`ifdef LSU_MISALIGN_EXC_EN
    chk("mis_keep", rdata_o, 32'h55AA55AA);
`else
    chk("mis_word", rdata_o, 32'h76543210);
`endif
    idle(2);

    // Reset while waiting for ack, then a stray late ack
    op(1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 1, 1'b0);
    idle(1);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h500;
    exp_busy = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h500;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_req = 1'b0; exp_busy = 1'b0; exp_rdata = '0;
    #1;
    chk("abort_req", dmem_req_o, 0);
    chk("abort_be", dmem_be_o, 0);
    chk("abort_rdata", rdata_o, 0);
    chk("abort_busy", busy_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    idle(2);
    chk("late_ack_done", done_o, 0);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
